// File: rtl/better_neighbor_writer_pkg.sv
// Shared memory map and state encoding for the better-neighbor writer and the winner policy.
package better_neighbor_writer_pkg;

  localparam int WORD_WIDTH = 16;

  localparam logic [15:0] TABLE_BASE    = 16'h0600;
  localparam logic [15:0] NCOUNT_ADDR   = 16'h0666;
  localparam logic [15:0] LIST_BASE     = 16'h0668;
  localparam logic [15:0] COUNT_ADDR    = 16'h068C;
  localparam logic [15:0] MAX_NEIGHBORS = 16'd25;
  localparam logic [15:0] MAX_BETTER    = 16'd18;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    LATCH_NCNT = 4'd1,
    LATCH_ID   = 4'd2,
    EVAL       = 4'd3,
    WR_ID      = 4'd4,
    WR_CNT     = 4'd5,
    DONE       = 4'd6
  } bnw_state_e;

  // Entry idx occupies two words: ID at base+4*idx, Q at base+4*idx+2 (16-bit wrap).
  function automatic logic [15:0] entryAddr(input logic [15:0] idx);
    return TABLE_BASE + {idx[13:0], 2'b00};
  endfunction

  function automatic logic [15:0] slotAddr(input logic [15:0] k);
    return LIST_BASE + {k[14:0], 1'b0};
  endfunction

endpackage

// File: rtl/better_neighbor_writer.sv
// Scans the neighbor table and writes IDs with Q below _mybest, then the kept count.
// Optional best-value tracking is enabled by defining BNW_BEST_TRACK_EN.
module better_neighbor_writer
  import better_neighbor_writer_pkg::*;
(
  input  logic        clock,
  input  logic        nreset,
  input  logic        start_bnWriter,
  input  logic [15:0] _mybest,
  input  logic [15:0] MY_NODE_ID,
  input  logic [15:0] data_in,
  output logic [15:0] address,
  output logic [15:0] data_out,
  output logic        wr_en,
  output logic        done_bnWriter,
  output logic [15:0] betterNeighborCount,
  output logic [15:0] bestvalue_out,
  output logic [15:0] bestneighbor_out,
  output logic [3:0]  cstate
);

  bnw_state_e  state_q;
  logic [15:0] address_q, dataOut_q, count_q;
  logic        wrEn_q, done_q;
  logic [15:0] n_q, i_q, k_q, id_q;
  logic [15:0] iNext;
  logic        lastEntry, isBetter;

  assign iNext     = i_q + 16'd1;
  assign lastEntry = (iNext == n_q);
  assign isBetter  = (data_in < _mybest) && (id_q != MY_NODE_ID) && (k_q < MAX_BETTER);

`ifdef BNW_BEST_TRACK_EN
  logic [15:0] bestQ_q, bestId_q, bestValOut_q, bestNbOut_q;
`endif

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q   <= IDLE;
      address_q <= '0;
      dataOut_q <= '0;
      wrEn_q    <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
      n_q       <= '0;
      i_q       <= '0;
      k_q       <= '0;
      id_q      <= '0;
`ifdef BNW_BEST_TRACK_EN
      bestQ_q      <= 16'hFFFF;
      bestId_q     <= '0;
      bestValOut_q <= 16'hFFFF;
      bestNbOut_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start_bnWriter) begin
            address_q <= NCOUNT_ADDR;
            state_q   <= LATCH_NCNT;
          end
        end
        LATCH_NCNT: begin
          n_q       <= (data_in > MAX_NEIGHBORS) ? MAX_NEIGHBORS : data_in;
          i_q       <= '0;
          k_q       <= '0;
          address_q <= TABLE_BASE;
`ifdef BNW_BEST_TRACK_EN
          bestQ_q   <= 16'hFFFF;
          bestId_q  <= '0;
`endif
          state_q   <= (data_in == 16'd0) ? WR_CNT : LATCH_ID;
        end
        LATCH_ID: begin
          id_q      <= data_in;
          address_q <= entryAddr(i_q) + 16'd2;
          state_q   <= EVAL;
        end
        EVAL: begin
          if (isBetter) begin
            address_q <= slotAddr(k_q);
            dataOut_q <= id_q;
            wrEn_q    <= 1'b1;
            k_q       <= k_q + 16'd1;
`ifdef BNW_BEST_TRACK_EN
            if (data_in < bestQ_q) begin
              bestQ_q  <= data_in;
              bestId_q <= id_q;
            end
`endif
            state_q   <= WR_ID;
          end else begin
            i_q <= iNext;
            if (lastEntry) begin
              state_q <= WR_CNT;
            end else begin
              address_q <= entryAddr(iNext);
              state_q   <= LATCH_ID;
            end
          end
        end
        WR_ID: begin
          wrEn_q <= 1'b0;
          i_q    <= iNext;
          if (lastEntry) begin
            state_q <= WR_CNT;
          end else begin
            address_q <= entryAddr(iNext);
            state_q   <= LATCH_ID;
          end
        end
        WR_CNT: begin
          address_q <= COUNT_ADDR;
          dataOut_q <= k_q;
          wrEn_q    <= 1'b1;
          state_q   <= DONE;
        end
        DONE: begin
          wrEn_q  <= 1'b0;
          count_q <= k_q;
`ifdef BNW_BEST_TRACK_EN
          bestValOut_q <= bestQ_q;
          bestNbOut_q  <= bestId_q;
`endif
          // Done is raised on entry and only dropped once the requester releases start.
          if (done_q && !start_bnWriter) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign address             = address_q;
  assign data_out            = dataOut_q;
  assign wr_en               = wrEn_q;
  assign done_bnWriter       = done_q;
  assign betterNeighborCount = count_q;
  assign cstate              = state_q;

`ifdef BNW_BEST_TRACK_EN
  assign bestvalue_out    = bestValOut_q;
  assign bestneighbor_out = bestNbOut_q;
`else
  assign bestvalue_out    = 16'hFFFF;
  assign bestneighbor_out = 16'h0000;
`endif

endmodule
